coin_acceptor: RTL

COIN_ACCEPTOR -- requirements
Module: coin_acceptor

---
 rtl/coin_pkg.sv | 20 ++
 rtl/coin_acceptor_if.sv | 20 ++
 rtl/coin_debounce.sv | 113 +++++++++++
 rtl/coin_acceptor.sv | 93 +++++++++
 4 files changed

// File: rtl/coin_pkg.sv
// Coin codes and channel-state encoding shared by the acceptor and the vending FSM.
package coin_pkg;

    typedef logic [1:0] coin_t;

    localparam coin_t COIN_NONE   = 2'b00;
    localparam coin_t COIN_NICKEL = 2'b10;
    localparam coin_t COIN_DIME   = 2'b11;

    typedef enum logic [1:0] {
        CH_IDLE = 2'd0,
        CH_DEB  = 2'd1,
        CH_HELD = 2'd2,
        CH_JAM  = 2'd3
    } ch_state_e;

    // Wide enough for JAM_CYCLES up to 65535.
    localparam int CNT_W = 16;

endpackage

// File: rtl/coin_acceptor_if.sv
// Sensor inputs and coin/jam outputs of the coin acceptor.
// COIN_COUNT_EN adds the per-type coin counters.
interface coin_acceptor_if;
    import coin_pkg::*;

    logic  nickel_raw;
    logic  dime_raw;
    coin_t coin;
    logic  jam;
`ifdef COIN_COUNT_EN
    logic [7:0] nickel_cnt;
    logic [7:0] dime_cnt;

    modport master (output nickel_raw, dime_raw, input coin, jam, nickel_cnt, dime_cnt);
    modport slave  (input nickel_raw, dime_raw, output coin, jam, nickel_cnt, dime_cnt);
`else
    modport master (output nickel_raw, dime_raw, input coin, jam);
    modport slave  (input nickel_raw, dime_raw, output coin, jam);
`endif
endinterface

// File: rtl/coin_debounce.sv
// One coin channel: two-flop synchronizer, debounce/jam FSM and channel counter.
//
// state   | meaning
// CH_IDLE | no coin present
// CH_DEB  | sensor high, counting consecutive high samples
// CH_HELD | coin validated, waiting for release or jam timeout
// CH_JAM  | sensor stuck high, no further coins until release
module coin_debounce
    import coin_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int JAM_CYCLES      = 1000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw_i,
    output logic valid_o,
    output logic jam_o
);

    // IDLE->DEB already takes the first high sample, so DEB needs D-1 more.
    localparam logic [CNT_W-1:0] DEB_TC = CNT_W'(DEBOUNCE_CYCLES - 2);
    localparam logic [CNT_W-1:0] JAM_TC = CNT_W'(JAM_CYCLES - 1);

    logic             sync1_q, sync2_q;
    logic             synced;
    ch_state_e        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             valid_q, valid_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= raw_i;
            sync2_q <= sync1_q;
        end
    end

    assign synced = sync2_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= CH_IDLE;
            cnt_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            valid_q <= valid_d;
        end
    end

    // Counter only advances below its terminal value, so it cannot wrap.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            CH_IDLE: begin
                if (synced) begin
                    state_d = CH_DEB;
                    cnt_d   = '0;
                end
            end
            CH_DEB: begin
                if (!synced) begin
                    state_d = CH_IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == DEB_TC) begin
                    state_d = CH_HELD;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            CH_HELD: begin
                if (!synced) begin
                    state_d = CH_IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == JAM_TC) begin
                    state_d = CH_JAM;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            CH_JAM: begin
                if (!synced) begin
                    state_d = CH_IDLE;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = CH_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_comb begin
        valid_d = 1'b0;
        jam_o   = 1'b0;
        if (state_q == CH_DEB && synced && cnt_q == DEB_TC) begin
            valid_d = 1'b1;
        end
        if (state_q == CH_JAM) begin
            jam_o = 1'b1;
        end
    end

    assign valid_o = valid_q;

endmodule

// File: rtl/coin_acceptor.sv
// Coin acceptor top: arbitrates nickel/dime channels into a registered coin code.
// Optional macro COIN_COUNT_EN adds saturating per-type coin counters.
module coin_acceptor
    import coin_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int JAM_CYCLES      = 1000
) (
    input  logic            clk,
    input  logic            rst_n,
    coin_acceptor_if.slave  bus
);

    logic  nck_valid, nck_jam;
    logic  dim_valid, dim_jam;
    coin_t coin_q, coin_d;
    logic  pend_q, pend_d;
    logic  jam_q,  jam_d;

    coin_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .JAM_CYCLES      (JAM_CYCLES)
    ) u_nickel (
        .clk     (clk),
        .rst_n   (rst_n),
        .raw_i   (bus.nickel_raw),
        .valid_o (nck_valid),
        .jam_o   (nck_jam)
    );

    coin_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .JAM_CYCLES      (JAM_CYCLES)
    ) u_dime (
        .clk     (clk),
        .rst_n   (rst_n),
        .raw_i   (bus.dime_raw),
        .valid_o (dim_valid),
        .jam_o   (dim_jam)
    );

    // Dime wins a collision; the nickel is parked in pend_q and emitted afterwards.
    always_comb begin
        coin_d = COIN_NONE;
        pend_d = pend_q;
        if (dim_valid) begin
            coin_d = COIN_DIME;
            pend_d = pend_q | nck_valid;
        end else if (pend_q || nck_valid) begin
            coin_d = COIN_NICKEL;
            pend_d = pend_q & nck_valid;
        end
    end

    assign jam_d = nck_jam | dim_jam;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            coin_q <= COIN_NONE;
            pend_q <= 1'b0;
            jam_q  <= 1'b0;
        end else begin
            coin_q <= coin_d;
            pend_q <= pend_d;
            jam_q  <= jam_d;
        end
    end

    assign bus.coin = coin_q;
    assign bus.jam  = jam_q;

`ifdef COIN_COUNT_EN
    logic [7:0] nickel_cnt_q, dime_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            nickel_cnt_q <= 8'd0;
            dime_cnt_q   <= 8'd0;
        end else begin
            if (coin_d == COIN_NICKEL && nickel_cnt_q != 8'hFF) begin
                nickel_cnt_q <= nickel_cnt_q + 8'd1;
            end
            if (coin_d == COIN_DIME && dime_cnt_q != 8'hFF) begin
                dime_cnt_q <= dime_cnt_q + 8'd1;
            end
        end
    end

    assign bus.nickel_cnt = nickel_cnt_q;
    assign bus.dime_cnt   = dime_cnt_q;
`endif

endmodule
